// File: rtl/key_turn_conditioner.sv
// Two-key debounce into a small turn FIFO: output rises at edge DEBOUNCE_CYCLES+3, held until game_tik pops it.
// Queue depth is 2 with TURN_QUEUE_EN defined, 1 otherwise; overflowing presses are dropped and flagged on turn_dropped.
module key_turn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_BIT         = 18
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic       key_left_n,
   input  logic       key_right_n,
   input  logic       game_tik,
   input  logic       start,
   input  logic       sync_reset,
   output logic       left_P,
   output logic       right_P,
   output logic       turn_dropped,
   output logic [1:0] queue_count
);

`ifdef TURN_QUEUE_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif

   localparam logic [CNT_BIT-1:0] CNT_LAST = CNT_BIT'(DEBOUNCE_CYCLES - 1);

   logic [1:0] raw_press;
   logic [1:0] press;

   assign raw_press = ~{key_right_n, key_left_n};

   // index 0 = left key, index 1 = right key
   for (genvar g = 0; g < 2; g++) begin : g_key
      logic               sync1;
      logic               sync2;
      logic               stable;
      logic               evt;
      logic [CNT_BIT-1:0] cnt;

      always_ff @(posedge clock_25 or negedge reset) begin
         if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            evt    <= 1'b0;
            cnt    <= '0;
         end else begin
            sync1 <= raw_press[g];
            sync2 <= sync1;
            evt   <= 1'b0;
            if (sync2 == stable) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               // event is registered alongside the level change so it costs no extra cycle
               stable <= sync2;
               evt    <= sync2;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign press[g] = evt;
   end

   logic [1:0] count;
   logic       entry0;
   logic       entry1;
   logic       push;
   logic       push_dat;
   logic       pop;
   logic       full;

   // simultaneous presses cancel each other
   assign push     = press[0] ^ press[1];
   assign push_dat = press[1];
   assign pop      = game_tik && (count != 2'd0);
   assign full     = (count == DEPTH);

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         count        <= 2'd0;
         entry0       <= 1'b0;
         entry1       <= 1'b0;
         turn_dropped <= 1'b0;
      end else begin
         turn_dropped <= 1'b0;
         if (sync_reset || !start) begin
            count <= 2'd0;
         end else if (pop && push) begin
            if (count == 2'd2) begin
               entry0 <= entry1;
               entry1 <= push_dat;
            end else begin
               entry0 <= push_dat;
            end
         end else if (pop) begin
            entry0 <= entry1;
            count  <= count - 2'd1;
         end else if (push) begin
            if (full) begin
               turn_dropped <= 1'b1;
            end else begin
               if (count == 2'd0) entry0 <= push_dat;
               else               entry1 <= push_dat;
               count <= count + 2'd1;
            end
         end
      end
   end

   assign left_P      = (count != 2'd0) && !entry0;
   assign right_P     = (count != 2'd0) &&  entry0;
   assign queue_count = count;

endmodule

// File: tb/tb_key_turn_conditioner.sv
// Bench for key_turn_conditioner: directed scenarios plus a randomized run against a window/queue reference model.
module tb_key_turn_conditioner;

   localparam int DB = 4;
`ifdef TURN_QUEUE_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_left_n;
   logic       key_right_n;
   logic       game_tik;
   logic       start;
   logic       sync_reset;
   logic       left_P;
   logic       right_P;
   logic       turn_dropped;
   logic [1:0] queue_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_turn_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_BIT(3)) dut (
      .clock_25     (clk),
      .reset        (rst_n),
      .key_left_n   (key_left_n),
      .key_right_n  (key_right_n),
      .game_tik     (game_tik),
      .start        (start),
      .sync_reset   (sync_reset),
      .left_P       (left_P),
      .right_P      (right_P),
      .turn_dropped (turn_dropped),
      .queue_count  (queue_count)
   );

   // Reference model: a level is accepted once the last DB synchronized samples all disagree with it.
   bit m_s1_l, m_s2_l, m_stab_l, m_evt_l;
   bit m_s1_r, m_s2_r, m_stab_r, m_evt_r;
   bit hist_l[$];
   bit hist_r[$];
   bit mq[$];
   bit m_drop;
   bit m_push, m_pop, m_val;

   function automatic bit all_differ(input bit h[$], input bit st);
      if (h.size() != DB) return 1'b0;
      foreach (h[k]) if (h[k] == st) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1_l = 0; m_s2_l = 0; m_stab_l = 0; m_evt_l = 0;
         m_s1_r = 0; m_s2_r = 0; m_stab_r = 0; m_evt_r = 0;
         hist_l.delete(); hist_r.delete(); mq.delete();
         m_drop = 0;
      end else begin
         m_push = m_evt_l ^ m_evt_r;
         m_val  = m_evt_r;
         m_pop  = game_tik && (mq.size() != 0);
         m_drop = 0;
         if (sync_reset || !start) begin
            mq.delete();
         end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
               if (mq.size() < DEPTH) mq.push_back(m_val);
               else m_drop = 1;
            end
         end
         hist_l.push_back(m_s2_l);
         if (hist_l.size() > DB) void'(hist_l.pop_front());
         m_evt_l = 0;
         if (all_differ(hist_l, m_stab_l)) begin
            m_stab_l = !m_stab_l;
            m_evt_l  = m_stab_l;
         end
         m_s2_l = m_s1_l;
         m_s1_l = !key_left_n;
         hist_r.push_back(m_s2_r);
         if (hist_r.size() > DB) void'(hist_r.pop_front());
         m_evt_r = 0;
         if (all_differ(hist_r, m_stab_r)) begin
            m_stab_r = !m_stab_r;
            m_evt_r  = m_stab_r;
         end
         m_s2_r = m_s1_r;
         m_s1_r = !key_right_n;
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic tik();
      game_tik = 1'b1;
      cyc(1);
      game_tik = 1'b0;
   endtask

   // which: 0 left, 1 right, 2 both; reports any turn_dropped and the peak queue_count seen
   task automatic press(input int which, output bit saw_drop, output int max_cnt);
      saw_drop = 0;
      max_cnt  = 0;
      if (which != 1) key_left_n  = 1'b0;
      if (which != 0) key_right_n = 1'b0;
      for (int i = 0; i < 2 * (DB + 8); i++) begin
         if (i == DB + 8) begin
            key_left_n  = 1'b1;
            key_right_n = 1'b1;
         end
         @(negedge clk);
         if (turn_dropped) saw_drop = 1;
         if (int'(queue_count) > max_cnt) max_cnt = int'(queue_count);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; key_left_n = 1'b1; key_right_n = 1'b1;
      game_tik = 1'b0; start = 1'b1; sync_reset = 1'b0;
      cyc(3);
      checks++; if (left_P !== 1'b0) begin errors++; $display("FAIL reset_left got %b want 0", left_P); end
      checks++; if (right_P !== 1'b0) begin errors++; $display("FAIL reset_right got %b want 0", right_P); end
      checks++; if (turn_dropped !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", turn_dropped); end
      checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", queue_count); end
   endtask

   task automatic test_latency();
      rst_n = 1'b1;
      key_left_n = 1'b0;
      for (int n = 1; n <= DB + 3; n++) begin
         @(negedge clk);
         if (n == DB + 2) begin
            checks++; if (left_P !== 1'b0) begin errors++; $display("FAIL early_left edge %0d got %b want 0", n, left_P); end
         end
      end
      checks++; if (left_P !== 1'b1) begin errors++; $display("FAIL latency_left got %b want 1", left_P); end
      checks++; if (queue_count !== 2'd1) begin errors++; $display("FAIL latency_count got %0d want 1", queue_count); end
      tik();
      checks++; if (left_P !== 1'b0) begin errors++; $display("FAIL pop_left got %b want 0", left_P); end
      checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL pop_count got %0d want 0", queue_count); end
      key_left_n = 1'b1;
      cyc(DB + 8);
      checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL release_count got %0d want 0", queue_count); end
   endtask

   task automatic test_bounce();
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) key_right_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (right_P || queue_count != 2'd0) seen = 1;
      end
      key_right_n = 1'b1;
      for (int i = 0; i < DB + 8; i++) begin
         @(negedge clk);
         if (right_P || queue_count != 2'd0) seen = 1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bounce_push got %b want 0", seen); end
   endtask

   task automatic test_overflow();
      bit d1, d2, d3;
      int mx;
      press(0, d1, mx);
      press(1, d2, mx);
      press(0, d3, mx);
      checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL ovf_drop1 got %b want 0", d1); end
      checks++; if (d2 !== (DEPTH == 1)) begin errors++; $display("FAIL ovf_drop2 got %b want %b", d2, DEPTH == 1); end
      checks++; if (d3 !== 1'b1) begin errors++; $display("FAIL ovf_drop3 got %b want 1", d3); end
      checks++; if (queue_count !== 2'(DEPTH)) begin errors++; $display("FAIL ovf_count got %0d want %0d", queue_count, DEPTH); end
      checks++; if (left_P !== 1'b1) begin errors++; $display("FAIL ovf_head_left got %b want 1", left_P); end
      tik();
      if (DEPTH == 2) begin
         checks++; if (right_P !== 1'b1) begin errors++; $display("FAIL ovf_head_right got %b want 1", right_P); end
         tik();
      end
      checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL ovf_empty got %0d want 0", queue_count); end
      checks++; if (left_P !== 1'b0 || right_P !== 1'b0) begin errors++; $display("FAIL ovf_outs got %b%b want 00", left_P, right_P); end
   endtask

   task automatic test_both_keys();
      bit d;
      int mx;
      press(2, d, mx);
      checks++; if (mx !== 0) begin errors++; $display("FAIL both_count got %0d want 0", mx); end
      checks++; if (d !== 1'b0) begin errors++; $display("FAIL both_drop got %b want 0", d); end
   endtask

   task automatic test_sync_reset_and_stop();
      bit d;
      int mx;
      press(0, d, mx);
      if (DEPTH == 2) press(1, d, mx);
      checks++; if (queue_count !== 2'(DEPTH)) begin errors++; $display("FAIL sr_fill got %0d want %0d", queue_count, DEPTH); end
      key_left_n = 1'b0;
      cyc(DB + 2);
      game_tik = 1'b1; sync_reset = 1'b1;
      cyc(1);
      game_tik = 1'b0; sync_reset = 1'b0;
      checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL sr_count got %0d want 0", queue_count); end
      checks++; if (turn_dropped !== 1'b0) begin errors++; $display("FAIL sr_drop got %b want 0", turn_dropped); end
      key_left_n = 1'b1;
      cyc(DB + 8);
      start = 1'b0;
      press(1, d, mx);
      checks++; if (mx !== 0) begin errors++; $display("FAIL stop_count got %0d want 0", mx); end
      checks++; if (d !== 1'b0) begin errors++; $display("FAIL stop_drop got %b want 0", d); end
      start = 1'b1;
      cyc(2);
   endtask

   task automatic test_async_reset();
      bit d;
      int mx;
      press(0, d, mx);
      press(1, d, mx);
      checks++; if (queue_count !== 2'(DEPTH)) begin errors++; $display("FAIL ar_fill got %0d want %0d", queue_count, DEPTH); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (queue_count !== 2'd0) begin errors++; $display("FAIL ar_count got %0d want 0", queue_count); end
      checks++; if (left_P !== 1'b0 || right_P !== 1'b0 || turn_dropped !== 1'b0) begin
         errors++; $display("FAIL ar_outs got %b%b%b want 000", left_P, right_P, turn_dropped);
      end
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic test_random();
      int hl = 0, hr = 0, ts = 0;
      bit el, er;
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         el = (mq.size() != 0) && (mq[0] == 1'b0);
         er = (mq.size() != 0) && (mq[0] == 1'b1);
         checks++; if (left_P !== el) begin errors++; $display("FAIL rnd_left cyc %0d got %b want %b", c, left_P, el); end
         checks++; if (right_P !== er) begin errors++; $display("FAIL rnd_right cyc %0d got %b want %b", c, right_P, er); end
         checks++; if (queue_count !== 2'(mq.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, queue_count, mq.size()); end
         checks++; if (turn_dropped !== m_drop) begin errors++; $display("FAIL rnd_drop cyc %0d got %b want %b", c, turn_dropped, m_drop); end
         if (hl == 0) begin key_left_n = !key_left_n; hl = $urandom_range(1, 12); end else hl--;
         if (hr == 0) begin key_right_n = !key_right_n; hr = $urandom_range(1, 12); end else hr--;
         game_tik   = ($urandom_range(0, 5) == 0);
         sync_reset = ($urandom_range(0, 60) == 0);
         if (ts == 0) begin start = ($urandom_range(0, 9) != 0); ts = $urandom_range(5, 40); end else ts--;
      end
      game_tik = 1'b0; sync_reset = 1'b0; start = 1'b1;
      key_left_n = 1'b1; key_right_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_bounce();
      test_overflow();
      test_both_keys();
      test_sync_reset_and_stop();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
